bram_port_arbiter: RTL

- Shares one block_ram instance (independent read and write ports, 1-cycle registered read) between two requesters, A and B.
- A is the matrix operand fetch unit; B is the result write-back / reload unit.
- The read port and the write port are arbitrated independently, each round-robin, so a read for one requester and a write for the other can both be granted in the same cycle.
- Read data is returned to the owning requester with a valid strobe one cycle after its grant.

---
 rtl/bram_port_arbiter_if.sv | 24 ++
 rtl/bram_port_arbiter.sv | 86 ++++++++
 2 files changed

// File: rtl/bram_port_arbiter_if.sv
// Requester-side bundle for bram_port_arbiter: one transaction request plus
// its grant and read-data return. Requester = master, arbiter = slave.
interface bram_port_arbiter_if #(
   parameter int W  = 8,
   parameter int AW = 5
);
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [W-1:0]  wdata;
   logic          gnt;
   logic          rvalid;
   logic [W-1:0]  rdata;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/bram_port_arbiter.sv
// Shares one read-first block_ram between requesters A and B. The read and write
// ports are arbitrated independently round-robin; read data returns one cycle after grant.
module bram_port_arbiter #(
   parameter int W = 8,
   parameter int L = 32,
   localparam int AW = $clog2(L)
) (
   input  logic               clk,
   input  logic               rst,
   bram_port_arbiter_if.slave port_a,
   bram_port_arbiter_if.slave port_b,
   output logic [AW-1:0]      ram_rd_addr,
   input  logic [W-1:0]       ram_rd_data,
   output logic               ram_wr_ena,
   output logic [AW-1:0]      ram_wr_addr,
   output logic [W-1:0]       ram_wr_data
);

   logic rd_req_a, rd_req_b, wr_req_a, wr_req_b;
   logic rd_gnt_a, rd_gnt_b, wr_gnt_a, wr_gnt_b;
   logic rd_last_q, rd_last_d;
   logic wr_last_q, wr_last_d;
   logic rv_pend_q, rv_pend_d;
   logic rv_owner_q, rv_owner_d;

   always_comb begin
      rd_req_a    = port_a.req & ~port_a.we;
      rd_req_b    = port_b.req & ~port_b.we;
      wr_req_a    = port_a.req &  port_a.we;
      wr_req_b    = port_b.req &  port_b.we;

      // On contention the requester that did not win last time takes the port.
      rd_gnt_a    = ~rst & rd_req_a & (~rd_req_b |  rd_last_q);
      rd_gnt_b    = ~rst & rd_req_b & (~rd_req_a | ~rd_last_q);
      wr_gnt_a    = ~rst & wr_req_a & (~wr_req_b |  wr_last_q);
      wr_gnt_b    = ~rst & wr_req_b & (~wr_req_a | ~wr_last_q);

      rd_last_d   = rd_last_q;
      wr_last_d   = wr_last_q;
      if (rd_gnt_a)      rd_last_d = 1'b0;
      else if (rd_gnt_b) rd_last_d = 1'b1;
      if (wr_gnt_a)      wr_last_d = 1'b0;
      else if (wr_gnt_b) wr_last_d = 1'b1;

      rv_pend_d   = rd_gnt_a | rd_gnt_b;
      rv_owner_d  = rd_gnt_b;

      ram_rd_addr = '0;
      if (rd_gnt_a)      ram_rd_addr = port_a.addr;
      else if (rd_gnt_b) ram_rd_addr = port_b.addr;

      ram_wr_ena  = wr_gnt_a | wr_gnt_b;
      ram_wr_addr = '0;
      ram_wr_data = '0;
      if (wr_gnt_a) begin
         ram_wr_addr = port_a.addr;
         ram_wr_data = port_a.wdata;
      end else if (wr_gnt_b) begin
         ram_wr_addr = port_b.addr;
         ram_wr_data = port_b.wdata;
      end

      port_a.gnt    = rd_gnt_a | wr_gnt_a;
      port_b.gnt    = rd_gnt_b | wr_gnt_b;
      // Gated by rst so a read granted just before reset never reports data.
      port_a.rvalid = ~rst & rv_pend_q & ~rv_owner_q;
      port_b.rvalid = ~rst & rv_pend_q &  rv_owner_q;
      port_a.rdata  = ram_rd_data;
      port_b.rdata  = ram_rd_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_last_q  <= 1'b1;
         wr_last_q  <= 1'b1;
         rv_pend_q  <= 1'b0;
         rv_owner_q <= 1'b0;
      end else begin
         rd_last_q  <= rd_last_d;
         wr_last_q  <= wr_last_d;
         rv_pend_q  <= rv_pend_d;
         rv_owner_q <= rv_owner_d;
      end
   end

endmodule
